mem_lsu: RTL and testbench

Memory-stage load/store unit: the consumer of the execute→memory pipeline register outputs. It turns aluresultM, writedataM, memwriteM, resultsrcM and funct3M into sized, lane-aligned transactions on a req/gnt/rvalid data bus. It stalls the pipeline until each access completes and returns a sign- or zero-extended load result for writeback.

---
 rtl/mem_lsu_pkg.sv | 21 ++
 rtl/mem_lsu_if.sv | 20 ++
 rtl/mem_lsu_align.sv | 49 ++++
 rtl/mem_lsu.sv | 82 ++++++++
 tb/tb_mem_lsu.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared encodings and the access-legality check for the memory-stage LSU.
package mem_lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  // Unsigned sizes exist for loads only; funct3[1:0] encodes the access size.
  function automatic logic f3_ok(input logic [2:0] f3, input logic store, input logic [1:0] off);
    logic legal, aligned;
    legal   = (f3 == F3_B) | (f3 == F3_H) | (f3 == F3_W) |
              (~store & ((f3 == F3_BU) | (f3 == F3_HU)));
    aligned = (f3[1:0] == 2'b10) ? (off == 2'b00) :
              (f3[1:0] == 2'b01) ? ~off[0] : 1'b1;
    return legal & aligned;
  endfunction
endpackage

// File: rtl/mem_lsu_if.sv
// req/gnt/rvalid data bus between the LSU (master) and memory (slave).
interface mem_lsu_if #(parameter int WIDTH = 32);
  logic             bus_req_o;
  logic             bus_we_o;
  logic [WIDTH-1:0] bus_addr_o;
  logic [3:0]       bus_be_o;
  logic [WIDTH-1:0] bus_wdata_o;
  logic             bus_gnt_i;
  logic             bus_rvalid_i;
  logic [WIDTH-1:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );
  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );
endinterface

// File: rtl/mem_lsu_align.sv
// Byte-lane steering: store replication + byte enables, load shift + extension.
module mem_lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       st_f3,
  input  logic [1:0]       st_off,
  input  logic [WIDTH-1:0] st_data,
  output logic [3:0]       st_be,
  output logic [WIDTH-1:0] st_wdata,
  input  logic [2:0]       ld_f3,
  input  logic [1:0]       ld_off,
  input  logic [WIDTH-1:0] ld_rdata,
  output logic [WIDTH-1:0] ld_data
);
  localparam int LW = WIDTH / 4;

  logic [WIDTH-1:0] shifted;

  // Sub-word stores replicate so every lane carries the value; be picks the lane.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign st_wdata[LW*i +: LW] = (st_f3[1:0] == 2'b00) ? st_data[LW-1:0] :
                                  (st_f3[1:0] == 2'b01) ? st_data[LW*(i%2) +: LW] :
                                                          st_data[LW*i +: LW];
  end

  always_comb begin
    st_be = 4'b1111;
    case (st_f3[1:0])
      2'b00:   st_be = 4'b0001 << st_off;
      2'b01:   st_be = st_off[1] ? 4'b1100 : 4'b0011;
      default: st_be = 4'b1111;
    endcase
  end

  assign shifted = ld_rdata >> (LW * ld_off);

  always_comb begin
    ld_data = shifted;
    case (ld_f3)
      F3_B:    ld_data = {{(WIDTH-LW){shifted[LW-1]}}, shifted[LW-1:0]};
      F3_H:    ld_data = {{(WIDTH-2*LW){shifted[2*LW-1]}}, shifted[2*LW-1:0]};
      F3_BU:   ld_data = {{(WIDTH-LW){1'b0}}, shifted[LW-1:0]};
      F3_HU:   ld_data = {{(WIDTH-2*LW){1'b0}}, shifted[2*LW-1:0]};
      default: ld_data = shifted;
    endcase
  end
endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: one bus transaction per access, stalling until done.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       resultsrcM,
  input  logic             memwriteM,
  input  logic [2:0]       funct3M,
  input  logic [WIDTH-1:0] aluresultM,
  input  logic [WIDTH-1:0] writedataM,
  output logic [WIDTH-1:0] readdataM,
  output logic             stallM,
  output logic             faultM,
  mem_lsu_if.master        bus
);
  lsu_state_t       state;
  logic [1:0]       off_q;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] rdata_q;
  logic             access, ok, start;
  logic [3:0]       be_n;
  logic [WIDTH-1:0] wdata_n, ld_data;

  mem_lsu_align #(.WIDTH(WIDTH)) u_align (
    .st_f3    (funct3M),
    .st_off   (aluresultM[1:0]),
    .st_data  (writedataM),
    .st_be    (be_n),
    .st_wdata (wdata_n),
    .ld_f3    (f3_q),
    .ld_off   (off_q),
    .ld_rdata (bus.bus_rdata_i),
    .ld_data  (ld_data)
  );

  assign access    = memwriteM | (resultsrcM == RESULTSRC_LOAD);
  assign ok        = f3_ok(funct3M, memwriteM, aluresultM[1:0]);
  assign faultM    = (state == IDLE) & access & ~ok;
  assign start     = (state == IDLE) & access & ok;
  assign stallM    = start | (state == REQ) | (state == WAIT);
  assign readdataM = faultM ? '0 : rdata_q;

  // DONE always returns to IDLE so the instruction still held in M is not reissued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      bus.bus_req_o   <= 1'b0;
      bus.bus_we_o    <= 1'b0;
      bus.bus_addr_o  <= '0;
      bus.bus_be_o    <= '0;
      bus.bus_wdata_o <= '0;
      off_q           <= '0;
      f3_q            <= '0;
      rdata_q         <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          bus.bus_req_o   <= 1'b1;
          bus.bus_we_o    <= memwriteM;
          bus.bus_addr_o  <= {aluresultM[WIDTH-1:2], 2'b00};
          bus.bus_be_o    <= be_n;
          bus.bus_wdata_o <= wdata_n;
          off_q           <= aluresultM[1:0];
          f3_q            <= funct3M;
          state           <= REQ;
        end
        REQ: if (bus.bus_gnt_i) begin
          bus.bus_req_o <= 1'b0;
          state         <= bus.bus_we_o ? DONE : WAIT;
        end
        WAIT: if (bus.bus_rvalid_i) begin
          rdata_q <= ld_data;
          state   <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu with an arithmetic reference model and a bus responder.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  resultsrcM;
  logic        memwriteM;
  logic [2:0]  funct3M;
  logic [31:0] aluresultM, writedataM, readdataM;
  logic        stallM, faultM;

  mem_lsu_if #(.WIDTH(32)) bus ();

  mem_lsu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .resultsrcM (resultsrcM),
    .memwriteM  (memwriteM),
    .funct3M    (funct3M),
    .aluresultM (aluresultM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .stallM     (stallM),
    .faultM     (faultM),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model from the access rules, in bytes and plain arithmetic.
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_fault(input bit st, input bit ld, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    if (!st && !ld) return 1'b0;
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 1'b1;
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int mask;
    mask = ((1 << m_size(f3)) - 1) << (a % 4);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (m_size(f3) == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (m_size(f3) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
    longint v;
    v = longint'(r >> (8 * (a % 4)));
    case (f3)
      3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
      3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
      3'd4: v = v % 256;
      3'd5: v = v % 65536;
      default: ;
    endcase
    return v[31:0];
  endfunction

  task automatic set_idle();
    memwriteM  = 1'b0;
    resultsrcM = 2'b00;
    funct3M    = 3'b000;
    aluresultM = '0;
    writedataM = '0;
  endtask

  // Entered and left #1 after a rising edge; drives one instruction and acts as the responder.
  task automatic access(input bit st, input bit ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] r, input int gd, input int rd,
                        input bit rst_in_wait);
    bit exp_f;
    int stalls;
    logic [1:0] other;
    other = 2'($urandom_range(0, 2));
    if (other == 2'b01) other = 2'b11;
    memwriteM  = st;
    resultsrcM = ld ? RESULTSRC_LOAD : other;
    funct3M    = f3;
    aluresultM = a;
    writedataM = d;
    bus.bus_gnt_i = 1'b0;
    bus.bus_rvalid_i = 1'b0;
    #1;
    exp_f = m_fault(st, ld, f3, a);
    chk("fault", {31'b0, faultM}, {31'b0, exp_f});
    if (!(st || ld) || exp_f) begin
      chk("idle_stall", {31'b0, stallM}, 32'd0);
      chk("idle_req", {31'b0, bus.bus_req_o}, 32'd0);
      if (exp_f) chk("fault_rdata", readdataM, 32'd0);
      @(posedge clk); #1;
      chk("no_req", {31'b0, bus.bus_req_o}, 32'd0);
      set_idle();
      return;
    end
    chk("start_stall", {31'b0, stallM}, 32'd1);
    stalls = 1;
    @(posedge clk); #1;
    chk("req", {31'b0, bus.bus_req_o}, 32'd1);
    chk("we", {31'b0, bus.bus_we_o}, {31'b0, st});
    chk("addr", bus.bus_addr_o, a & 32'hFFFF_FFFC);
    chk("be", {28'b0, bus.bus_be_o}, {28'b0, m_be(f3, a)});
    if (st) chk("wdata", bus.bus_wdata_o, m_wdata(f3, d));
    for (int k = 0; k <= gd; k++) begin
      bus.bus_gnt_i    = (k == gd);
      bus.bus_rvalid_i = (k != gd) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.bus_rdata_i  = $urandom;
      #1;
      chk("req_stall", {31'b0, stallM}, 32'd1);
      chk("req_hold", {31'b0, bus.bus_req_o}, 32'd1);
      chk("addr_hold", bus.bus_addr_o, a & 32'hFFFF_FFFC);
      stalls++;
      @(posedge clk); #1;
    end
    bus.bus_gnt_i = 1'b0;
    bus.bus_rvalid_i = 1'b0;
    if (!st) begin
      for (int k = 0; k <= rd; k++) begin
        if (rst_in_wait && k == rd) begin
          set_idle();
          bus.bus_rvalid_i = 1'b1;
          bus.bus_rdata_i  = r;
          rst = 1'b1;
          #1;
          chk("rst_req", {31'b0, bus.bus_req_o}, 32'd0);
          chk("rst_we", {31'b0, bus.bus_we_o}, 32'd0);
          chk("rst_addr", bus.bus_addr_o, 32'd0);
          chk("rst_be", {28'b0, bus.bus_be_o}, 32'd0);
          chk("rst_wdata", bus.bus_wdata_o, 32'd0);
          chk("rst_rdata", readdataM, 32'd0);
          chk("rst_stall", {31'b0, stallM}, 32'd0);
          @(posedge clk); #1;
          rst = 1'b0;
          bus.bus_rvalid_i = 1'b0;
          @(posedge clk); #1;
          chk("post_rst_rdata", readdataM, 32'd0);
          chk("post_rst_req", {31'b0, bus.bus_req_o}, 32'd0);
          return;
        end
        bus.bus_rvalid_i = (k == rd);
        bus.bus_rdata_i  = (k == rd) ? r : $urandom;
        bus.bus_gnt_i    = 1'($urandom_range(0, 1));
        #1;
        chk("wait_stall", {31'b0, stallM}, 32'd1);
        stalls++;
        @(posedge clk); #1;
      end
      bus.bus_gnt_i = 1'b0;
      bus.bus_rvalid_i = 1'b0;
      chk("rdata", readdataM, m_load(f3, a, r));
    end
    chk("done_stall", {31'b0, stallM}, 32'd0);
    chk("done_req", {31'b0, bus.bus_req_o}, 32'd0);
    chk("stall_cycles", stalls, st ? gd + 2 : gd + rd + 3);
    set_idle();
    @(posedge clk); #1;
  endtask

  initial begin
    bit st, ld;
    logic [2:0] f3;
    logic [31:0] a;
    rst = 1'b1;
    set_idle();
    bus.bus_gnt_i = 1'b0;
    bus.bus_rvalid_i = 1'b0;
    bus.bus_rdata_i = '0;
    #1;
    chk("reset_req", {31'b0, bus.bus_req_o}, 32'd0);
    chk("reset_addr", bus.bus_addr_o, 32'd0);
    chk("reset_be", {28'b0, bus.bus_be_o}, 32'd0);
    chk("reset_rdata", readdataM, 32'd0);
    chk("reset_stall", {31'b0, stallM}, 32'd0);
    resultsrcM = RESULTSRC_LOAD;
    funct3M    = F3_W;
    #1;
    chk("reset_stall_follows", {31'b0, stallM}, 32'd1);
    set_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    access(1, 0, F3_W,  32'h0000_1008, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
    access(1, 0, F3_B,  32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0, 0);
    access(0, 1, F3_B,  32'h0000_2001, 32'h0,         32'h1234_80FF, 0, 0, 0);
    access(0, 1, F3_HU, 32'h0000_2002, 32'h0,         32'h8001_0000, 0, 0, 0);
    access(0, 1, F3_W,  32'h0000_2002, 32'h0,         32'h0, 0, 0, 0);
    access(0, 1, F3_W,  32'h0000_2000, 32'h0,         32'h5555_AAAA, 3, 1, 1);
    access(0, 1, F3_W,  32'h0000_3000, 32'h0,         32'h0BAD_F00D, 0, 0, 0);
    access(1, 1, F3_BU, 32'h0000_3001, 32'h0000_0077, 32'h0, 0, 0, 0);
    access(1, 0, F3_H,  32'h0000_3002, 32'h0000_BEEF, 32'h0, 1, 0, 0);

    for (int i = 0; i < 60; i++) begin
      st = 1'($urandom_range(0, 1));
      ld = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 9) < 7) a = a & ~(32'(m_size(f3)) - 1);
      access(st, ld, f3, a, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
